key_conditioner: RTL
====================

# key_conditioner

Front-end conditioner for one active-low board pushbutton feeding the lab counters (`main_counter` and its successors). It synchronises the raw key into the `CLK_50` domain and rejects bounce with a stability counter. It emits a clean level plus single-cycle press/release strobes that downstream counters use as count-enable or clear. One instance is used per key.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000 (20 ms at 50 MHz): consecutive stable synchronised samples required to accept a change; legal range ≥2.
- `REPEAT_DELAY`, default 25_000_000: cycles from accepted press to first auto-repeat strobe; ≥1.
- `REPEAT_PERIOD`, default 5_000_000: cycles between subsequent auto-repeat strobes; ≥1.
- `CLK_50`  in  1  sole clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `key_n`  in  1  raw asynchronous pushbutton; 0 = pressed.
- `pressed`  out  1  debounced level; 1 while key accepted as held.
- `press_pulse`  out  1  one-cycle strobe on accepted press (and auto-repeats when enabled).
- `release_pulse`  out  1  one-cycle strobe on accepted release.

## Operation
- Two-flop synchroniser on `key_n`; `pressed_s` = inverted second-stage output. On `rst`, both stages load 1 (released).
- FSM states: IDLE, PRESS_CHK, HELD, REL_CHK. Stability counter `cnt`, width `$clog2(DEBOUNCE_CYCLES)`.
- IDLE: `pressed_s`=1 → PRESS_CHK, `cnt`←0.
- PRESS_CHK: `pressed_s`=0 → IDLE, no strobe (bounce rejected). `pressed_s`=1 and `cnt`==DEBOUNCE_CYCLES-1 → HELD, `press_pulse`←1, `pressed`←1. Otherwise `cnt`++.
- HELD: `pressed_s`=0 → REL_CHK, `cnt`←0.
- REL_CHK is the mirror of PRESS_CHK:
  - `pressed_s`=1 → HELD, no strobe.
  - Count complete → IDLE, `release_pulse`←1, `pressed`←0.
- All outputs registered. Strobes last exactly one cycle. `press_pulse` and `release_pulse` are never high together.
- Reset values: state IDLE, `cnt`=0, `pressed`=0, `press_pulse`=0, `release_pulse`=0, repeat counter 0.
- `rst` in any state, including mid-check, discards progress. A key held through reset is re-debounced from scratch and yields one `press_pulse`.
- `cnt` never wraps: it saturates by leaving the check state.

## Timing
- With `key_n` low and stable before edge E0, `press_pulse` and `pressed` rise after edge E(DEBOUNCE_CYCLES+2). Breakdown: 2 sync edges, 1 IDLE→PRESS_CHK edge, DEBOUNCE_CYCLES-1 count edges, 1 accept edge.
- Release latency is identical, measured from `key_n` high.
- Minimum accepted press width: DEBOUNCE_CYCLES+1 samples low. Any shorter low excursion produces no output activity.

## Configuration
- `KEY_AUTOREPEAT_EN` defined:
  - A repeat counter runs in HELD.
  - `press_pulse` repeats REPEAT_DELAY cycles after the accepted-press strobe, then every REPEAT_PERIOD cycles while in HELD.
  - The counter holds its value during REL_CHK and resumes if the check returns to HELD.
  - The counter clears on entry to IDLE.
- Not defined: no repeat counter is synthesised; `press_pulse` fires once per accepted press. REPEAT_* parameters are ignored.

## Structure
- Package `key_cond_pkg`:
  - `key_state_t` enum (IDLE, PRESS_CHK, HELD, REL_CHK).
  - Default constants `KEY_DEBOUNCE_DEF`, `KEY_REPEAT_DELAY_DEF`, `KEY_REPEAT_PERIOD_DEF`.
- Sub-module `sync_2ff`: generic two-flop synchroniser with parameter `RST_VAL`; reused by later labs.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5, with 10 ns clock.
- Clean press at E0, held 40 cycles: `press_pulse` high for exactly one cycle after E6 and `pressed`=1 from E6. Autorepeat off: no further strobes.
- Bounce: `key_n` low 3 cycles, high 2, repeated 5 times, then high: `press_pulse`, `release_pulse` and `pressed` stay 0 throughout.
- Release after stable hold, `key_n` high at E20: `release_pulse` one cycle after E26; `pressed`=0 from E26.
- Reset mid-PRESS_CHK: `rst`=1 for one cycle at E4 with key still low. No strobe at E6, all outputs 0 during reset, `press_pulse` after E5+6=E11.
- `KEY_AUTOREPEAT_EN` defined, press at E0 held 40 cycles: `press_pulse` after E6, E16, E21, E26, E31, E36, E41.
- Release glitch during HELD (`key_n` high 2 cycles): no `release_pulse`, `pressed` stays 1. With autorepeat, the next repeat is delayed only by the time spent in REL_CHK.

Source files
------------

// File: rtl/key_cond_pkg.sv
`default_nettype none
// ============================================================================
// Module      : key_cond_pkg
// Description : Shared types and default constants for the key conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
package key_cond_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } key_state_t;

    // Defaults assume a 50 MHz clock: 20 ms debounce, 0.5 s delay, 0.1 s rate
    localparam int KEY_DEBOUNCE_DEF      = 1_000_000;
    localparam int KEY_REPEAT_DELAY_DEF  = 25_000_000;
    localparam int KEY_REPEAT_PERIOD_DEF = 5_000_000;

    function automatic int key_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : key_cond_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Generic two-flop synchroniser with a configurable reset value.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/key_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : key_conditioner
// Description : Synchronise and debounce one active-low pushbutton, producing
//               a clean level and press/release strobes. Optional auto-repeat
//               of press_pulse is enabled with `define KEY_AUTOREPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEF,
    parameter int REPEAT_DELAY    = KEY_REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = KEY_REPEAT_PERIOD_DEF
) (
    input  logic CLK_50,
    input  logic rst,
    input  logic key_n,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int                 c_CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic               w_key_n_s;
    logic               w_pressed_s;
    key_state_t         r_state;
    logic [c_CNT_W-1:0] r_cnt;

    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (CLK_50),
        .rst (rst),
        .i_d (key_n),
        .o_q (w_key_n_s)
    );

    assign w_pressed_s = ~w_key_n_s;

`ifdef KEY_AUTOREPEAT_EN
    localparam int                 c_REP_W      = $clog2(key_max(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [c_REP_W-1:0] c_REP_DLY_M1 = c_REP_W'(REPEAT_DELAY - 1);
    localparam logic [c_REP_W-1:0] c_REP_PER_M1 = c_REP_W'(REPEAT_PERIOD - 1);

    logic [c_REP_W-1:0] r_rep_cnt;
    logic               r_rep_first;
    logic [c_REP_W-1:0] w_rep_lim;

    // First repeat waits the long delay, later ones use the short period
    assign w_rep_lim = r_rep_first ? c_REP_DLY_M1 : c_REP_PER_M1;
`else
    localparam int c_unused_repeat_cfg = REPEAT_DELAY + REPEAT_PERIOD;
`endif

    always_ff @(posedge CLK_50) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            r_rep_cnt     <= '0;
            r_rep_first   <= 1'b1;
`endif
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pressed_s) begin
                        r_state <= PRESS_CHK;
                        r_cnt   <= '0;
                    end
                end
                PRESS_CHK: begin
                    if (!w_pressed_s) begin
                        r_state <= IDLE;
                    end else if (r_cnt == c_CNT_MAX) begin
                        r_state     <= HELD;
                        press_pulse <= 1'b1;
                        pressed     <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!w_pressed_s) begin
                        r_state <= REL_CHK;
                        r_cnt   <= '0;
                    end
`ifdef KEY_AUTOREPEAT_EN
                    // Repeat counter only advances on cycles spent in HELD
                    if (r_rep_cnt == w_rep_lim) begin
                        press_pulse <= 1'b1;
                        r_rep_cnt   <= '0;
                        r_rep_first <= 1'b0;
                    end else begin
                        r_rep_cnt <= r_rep_cnt + 1'b1;
                    end
`endif
                end
                REL_CHK: begin
                    if (w_pressed_s) begin
                        r_state <= HELD;
                    end else if (r_cnt == c_CNT_MAX) begin
                        r_state       <= IDLE;
                        release_pulse <= 1'b1;
                        pressed       <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
                        r_rep_cnt     <= '0;
                        r_rep_first   <= 1'b1;
`endif
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : key_conditioner
`default_nettype wire
